// File: rtl/fpga_cfg_loader_if.sv
// Valid/ready word stream that carries framed configuration data into fpga_cfg_loader.
interface fpga_cfg_loader_if;
    logic [15:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/fpga_cfg_loader.sv
// Streaming configuration loader: framed words fill shadow copies of the fabric
// configuration vectors, and a commit frame moves every shadow to the outputs at once.
module fpga_cfg_loader #(
    parameter int wire_width  = 7,
    parameter int lb_cfg_size = 10,
    parameter int fpga_width  = 5,
    parameter int fpga_height = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fpga_cfg_loader_if.slave        cfg,
    output logic [fpga_height*fpga_width*wire_width*12-1:0]                       brbselect,
    output logic [(fpga_height-1)*(fpga_width-1)*wire_width*wire_width*12-1:0]    bsbselect,
    output logic [fpga_width*fpga_height*lb_cfg_size-1:0]                         lbselect,
    output logic [2*wire_width*fpga_height-1:0]                                   leftioselect,
    output logic [2*wire_width*fpga_height-1:0]                                   rightioselect,
    output logic [2*wire_width*fpga_height-1:0]                                   topioselect,
    output logic [2*wire_width*fpga_height-1:0]                                   bottomioselect,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic                    cfg_error
);
    localparam int brb_w  = fpga_height*fpga_width*wire_width*12;
    localparam int bsb_w  = (fpga_height-1)*(fpga_width-1)*wire_width*wire_width*12;
    localparam int lb_w   = fpga_width*fpga_height*lb_cfg_size;
    localparam int io_w   = 2*wire_width*fpga_height;
    localparam int brb_aw = $clog2(brb_w);
    localparam int bsb_aw = $clog2(bsb_w);
    localparam int lb_aw  = $clog2(lb_w);
    localparam int io_aw  = $clog2(io_w);
    localparam int ptr_w  = 20;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, SKIP, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         region_q;
    logic [11:0]        remain_q;
    logic [ptr_w-1:0]   ptr_q;
    logic [ptr_w-1:0]   bit_idx [16];
    logic [3:0]         hdr_region;
    logic [11:0]        hdr_len;
    logic               accept;
    logic               wr_en;
    logic [1:0]         io_sel;

    logic [brb_w-1:0]   brb_sh;
    logic [bsb_w-1:0]   bsb_sh;
    logic [lb_w-1:0]    lb_sh;
    logic [io_w-1:0]    io_sh [4];

    // Regions 3..6 are the left/right/top/bottom IO shadows in that order.
    function automatic logic [ptr_w-1:0] region_width(input logic [3:0] region);
        case (region)
            4'd0:                   return ptr_w'(brb_w);
            4'd1:                   return ptr_w'(bsb_w);
            4'd2:                   return ptr_w'(lb_w);
            4'd3, 4'd4, 4'd5, 4'd6: return ptr_w'(io_w);
            default:                return '0;
        endcase
    endfunction

    assign hdr_region = cfg.cfg_data[15:12];
    assign hdr_len    = cfg.cfg_data[11:0];
    assign accept     = cfg.cfg_valid && cfg.cfg_ready;
    assign wr_en      = accept && (state_q == DATA);
    assign io_sel     = 2'(region_q - 4'd3);
    assign cfg_busy   = (state_q != IDLE);

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            bit_idx[i] = ptr_q + ptr_w'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        cfg.cfg_ready = 1'b1;
        cfg_done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hdr_region <= 4'd6)      state_d = ADDR;
                    else if (hdr_region == 4'd7) state_d = COMMIT;
                    else if (hdr_len != 12'd0)   state_d = SKIP;
                end
            end
            ADDR: begin
                if (accept) state_d = (remain_q == 12'd0) ? IDLE : DATA;
            end
            DATA, SKIP: begin
                if (accept && remain_q == 12'd1) state_d = IDLE;
            end
            COMMIT: begin
                cfg.cfg_ready = 1'b0;
                cfg_done      = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // remain_q counts words still owed by the current frame; ptr_q is the shadow bit of data bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            region_q  <= '0;
            remain_q  <= '0;
            ptr_q     <= '0;
            cfg_error <= 1'b0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    region_q <= hdr_region;
                    remain_q <= hdr_len;
                    if (hdr_region[3]) cfg_error <= 1'b1;
                end
                ADDR: ptr_q <= {{(ptr_w-16){1'b0}}, cfg.cfg_data};
                DATA: begin
                    ptr_q    <= ptr_q + ptr_w'(16);
                    remain_q <= remain_q - 12'd1;
                    if (bit_idx[15] >= region_width(region_q)) cfg_error <= 1'b1;
                end
                SKIP: remain_q <= remain_q - 12'd1;
                default: ;
            endcase
        end
    end

    // Bits beyond the region width are simply not written; the error flag above records them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brb_sh <= '0;
            bsb_sh <= '0;
            lb_sh  <= '0;
            for (int r = 0; r < 4; r++) io_sh[r] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < 16; i++) begin
                if (bit_idx[i] < region_width(region_q)) begin
                    case (region_q)
                        4'd0:    brb_sh[bit_idx[i][brb_aw-1:0]] <= cfg.cfg_data[i];
                        4'd1:    bsb_sh[bit_idx[i][bsb_aw-1:0]] <= cfg.cfg_data[i];
                        4'd2:    lb_sh[bit_idx[i][lb_aw-1:0]]   <= cfg.cfg_data[i];
                        default: io_sh[io_sel][bit_idx[i][io_aw-1:0]] <= cfg.cfg_data[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brbselect      <= '0;
            bsbselect      <= '0;
            lbselect       <= '0;
            leftioselect   <= '0;
            rightioselect  <= '0;
            topioselect    <= '0;
            bottomioselect <= '0;
        end else if (state_q == COMMIT) begin
            brbselect      <= brb_sh;
            bsbselect      <= bsb_sh;
            lbselect       <= lb_sh;
            leftioselect   <= io_sh[0];
            rightioselect  <= io_sh[1];
            topioselect    <= io_sh[2];
            bottomioselect <= io_sh[3];
        end
    end
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader: framed loads, commits, skips, stalls and mid-frame reset.
module tb_fpga_cfg_loader;
    localparam int BRB_W = 2100;
    localparam int BSB_W = 9408;
    localparam int LB_W  = 250;
    localparam int IO_W  = 70;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fpga_cfg_loader_if bus ();

    logic [BRB_W-1:0] brbselect;
    logic [BSB_W-1:0] bsbselect;
    logic [LB_W-1:0]  lbselect;
    logic [IO_W-1:0]  leftioselect, rightioselect, topioselect, bottomioselect;
    logic             cfg_busy, cfg_done, cfg_error;

    int vectors     = 0;
    int miscompares = 0;

    fpga_cfg_loader #(
        .wire_width (7),
        .lb_cfg_size(10),
        .fpga_width (5),
        .fpga_height(5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg           (bus),
        .brbselect     (brbselect),
        .bsbselect     (bsbselect),
        .lbselect      (lbselect),
        .leftioselect  (leftioselect),
        .rightioselect (rightioselect),
        .topioselect   (topioselect),
        .bottomioselect(bottomioselect),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_error     (cfg_error)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word has transferred.
    task automatic applyStimulus(input logic [15:0] word);
        int waited = 0;
        bus.cfg_data  = word;
        bus.cfg_valid = 1'b1;
        while (bus.cfg_ready !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 10) begin
            miscompares++;
            $error("[TB] FAIL handshake: observed ready stuck low expected ready within 10 cycles");
        end
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic doCommit(input string tag);
        int done_cycles  = 0;
        int stall_cycles = 0;
        applyStimulus(16'h7000);
        for (int c = 0; c < 5; c++) begin
            if (cfg_done === 1'b1) done_cycles++;
            if (bus.cfg_ready === 1'b0) stall_cycles++;
            @(negedge clk);
        end
        checkOutput({tag, "_done_pulses"}, 128'(done_cycles), 128'd1);
        checkOutput({tag, "_ready_low"}, 128'(stall_cycles), 128'd1);
    endtask

    function automatic int totalOnes();
        return $countones(brbselect) + $countones(bsbselect) + $countones(lbselect) +
               $countones(leftioselect) + $countones(rightioselect) +
               $countones(topioselect) + $countones(bottomioselect);
    endfunction

    initial begin
        int busy_cycles;
        logic [IO_W-1:0] exp_top;

        bus.cfg_data  = 16'h0000;
        bus.cfg_valid = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", 128'(bus.cfg_ready), 128'd1);
        checkOutput("reset_busy",  128'(cfg_busy),      128'd0);
        checkOutput("reset_done",  128'(cfg_done),      128'd0);
        checkOutput("reset_error", 128'(cfg_error),     128'd0);
        checkOutput("reset_ones",  128'(totalOnes()),   128'd0);

        // Single bit into left IO, then commit.
        applyStimulus(16'h3001);
        checkOutput("hdr_busy", 128'(cfg_busy), 128'd1);
        applyStimulus(16'h0000);
        applyStimulus(16'h0001);
        checkOutput("pre_commit_left", 128'(leftioselect), 128'd0);
        doCommit("c1");
        checkOutput("c1_left",  128'(leftioselect), 128'd1);
        checkOutput("c1_ones",  128'(totalOnes()),  128'd1);
        checkOutput("c1_error", 128'(cfg_error),    128'd0);

        // Two BRB words at offset 4; outputs must wait for the commit.
        applyStimulus(16'h0002);
        applyStimulus(16'h0004);
        applyStimulus(16'h0002);
        applyStimulus(16'h8000);
        checkOutput("c2_pre_brb", 128'($countones(brbselect)), 128'd0);
        doCommit("c2");
        checkOutput("c2_brb_ones", 128'($countones(brbselect)), 128'd2);
        checkOutput("c2_brb5",     128'(brbselect[5]),          128'd1);
        checkOutput("c2_brb35",    128'(brbselect[35]),         128'd1);
        checkOutput("c2_left",     128'(leftioselect),          128'd1);

        // Invalid region: its two words (which look like a frame) must be skipped.
        applyStimulus(16'h9002);
        checkOutput("skip_error", 128'(cfg_error), 128'd1);
        checkOutput("skip_busy",  128'(cfg_busy),  128'd1);
        applyStimulus(16'h3001);
        applyStimulus(16'h0000);
        checkOutput("skip_idle",  128'(cfg_busy),  128'd0);
        applyStimulus(16'h6001);
        applyStimulus(16'h0000);
        applyStimulus(16'h0001);
        doCommit("c3");
        checkOutput("c3_bottom", 128'(bottomioselect), 128'd1);
        checkOutput("c3_left",   128'(leftioselect),   128'd1);
        checkOutput("c3_ones",   128'(totalOnes()),    128'd4);

        // Word straddling the end of left IO: only bits 64..69 land.
        applyStimulus(16'h3001);
        applyStimulus(16'h0040);
        applyStimulus(16'hFFFF);
        doCommit("c4");
        checkOutput("c4_left",  128'(leftioselect), 128'(70'h3F_0000_0000_0000_0001));
        checkOutput("c4_error", 128'(cfg_error),    128'd1);
        checkOutput("c4_ones",  128'(totalOnes()),  128'd10);

        // len=3 top IO frame with 20-cycle valid gaps between data words.
        applyStimulus(16'h5003);
        applyStimulus(16'h0003);
        applyStimulus(16'hA5A5);
        busy_cycles = 0;
        repeat (20) begin
            if (cfg_busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        checkOutput("stall1_busy", 128'(busy_cycles), 128'd20);
        applyStimulus(16'h1234);
        busy_cycles = 0;
        repeat (20) begin
            if (cfg_busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        checkOutput("stall2_busy", 128'(busy_cycles), 128'd20);
        applyStimulus(16'h00FF);
        checkOutput("stall_end_busy", 128'(cfg_busy), 128'd0);
        doCommit("c5");
        exp_top = 70'h00FF_1234_A5A5 << 3;
        checkOutput("c5_top", 128'(topioselect), 128'(exp_top));

        // Reset in the middle of a right IO frame.
        applyStimulus(16'h4002);
        applyStimulus(16'h0000);
        applyStimulus(16'h0F0F);
        checkOutput("mid_busy", 128'(cfg_busy), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ones",  128'(totalOnes()), 128'd0);
        checkOutput("rst_busy",  128'(cfg_busy),    128'd0);
        checkOutput("rst_error", 128'(cfg_error),   128'd0);
        checkOutput("rst_done",  128'(cfg_done),    128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", 128'(bus.cfg_ready), 128'd1);
        applyStimulus(16'h4001);
        applyStimulus(16'h0008);
        applyStimulus(16'h00FF);
        doCommit("c6");
        checkOutput("c6_right", 128'(rightioselect), 128'h0000_FF00);
        checkOutput("c6_ones",  128'(totalOnes()),   128'd8);
        checkOutput("c6_error", 128'(cfg_error),     128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- Streaming configuration controller for fpga_top.
- Accepts a framed 16-bit word stream over a valid/ready handshake and writes it into shadow copies of the seven configuration vectors: brbselect, bsbselect, lbselect, and left/right/top/bottom ioselect.
- A commit frame copies all shadows into the active outputs in one cycle, so the fabric never sees a partially written configuration.
- Sits between the host/bitstream source and fpga_top's configuration ports.

Parameters:
- wire_width, 7, routing tracks per channel
- lb_cfg_size, 10, configuration bits per logic block
- fpga_width, 5, logic block columns
- fpga_height, 5, logic block rows

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_data  in  16  configuration stream word
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  loader accepts word this cycle
- brbselect  out  fpga_height*fpga_width*wire_width*12  active BRB config
- bsbselect  out  (fpga_height-1)*(fpga_width-1)*wire_width*wire_width*12  active BSB config
- lbselect  out  fpga_width*fpga_height*lb_cfg_size  active LB config
- leftioselect, rightioselect, topioselect, bottomioselect  out  2*wire_width*fpga_height each  active IO config
- cfg_busy  out  1  frame in progress (state != IDLE)
- cfg_done  out  1  one-cycle pulse when commit takes effect
- cfg_error  out  1  sticky error flag

Behaviour:
- A word transfers on a rising clk edge when cfg_valid && cfg_ready.
- Frame format:
  - Word 0 (header): [15:12] region, [11:0] len (number of data words).
  - Region codes: 0 brb, 1 bsb, 2 lb, 3 left, 4 right, 5 top, 6 bottom, 7 commit, 8-15 invalid.
  - Data regions (0-6): word 1 is the start bit offset (16-bit unsigned), followed by len data words.
  - Commit (7): header only; len field ignored.
- Bit mapping: data word k, bit i (i = 0..15) writes shadow bit offset + 16*k + i of the selected region. No read-modify of other bits.
- Out-of-range bits (index >= region width) are dropped and cfg_error is set; in-range bits of the same word are still written.
- FSM states:
  - IDLE, cfg_ready=1. Accepting a header with region 0-6 → ADDR. Region 7 → COMMIT. Region 8-15 → SKIP with len counter loaded and cfg_error set; if len=0 → stay in IDLE.
  - ADDR, cfg_ready=1. Accepting a word latches the offset. Then len=0 → IDLE; else → DATA.
  - DATA, cfg_ready=1. Each accepted word is written to the shadow and the write pointer advances by 16. On the last word (counter reaches len) → IDLE.
  - SKIP, cfg_ready=1. Consumes len words without writing, then → IDLE.
  - COMMIT, cfg_ready=0 for exactly one cycle. All seven active outputs load their shadows on that edge, cfg_done=1 for that cycle, then → IDLE.
- Shadow write latency: a shadow bit updates on the same edge the word is accepted. Active outputs change only in COMMIT.
- Shadows persist across commits, so a partial reload followed by a commit updates only the rewritten bits.
- cfg_valid low mid-frame: the FSM holds state and counters indefinitely; there is no timeout.
- The len and pointer arithmetic is wide enough that offset + 16*len does not wrap; anything beyond the region width is treated as out-of-range.
- cfg_error clears only on reset.
- Reset (async assert, any state including mid-frame):
  - FSM → IDLE.
  - All shadows and active outputs → 0 (all switches off).
  - cfg_busy=0, cfg_done=0, cfg_error=0, cfg_ready=1 once reset is deasserted.

Test Plan:
- Frame 0x3001, 0x0000, 0x0001, then commit 0x7000 → leftioselect[0]=1; cfg_done pulses once; cfg_ready=0 for exactly that one cycle; all other outputs stay 0.
- Frame 0x0002, offset 0x0004, data 0x0002, 0x8000, without commit → brbselect stays 0. After commit 0x7000 → brbselect[5]=1 and brbselect[35]=1 only.
- Frame 0x3001, offset 0x0040 (bit 64 of 70), data 0xFFFF, commit → leftioselect[69:64]=6'h3F, cfg_error=1, no other bits set.
- Invalid header 0x9002 followed by 2 words, then frame 0x6001/0x0000/0x0001 and commit → the two words are skipped; bottomioselect[0]=1; cfg_error=1.
- cfg_valid dropped for 20 cycles between data words of a len=3 frame → cfg_busy stays 1 throughout; the final shadow contents match an unstalled load.
- rst_n asserted mid-DATA after a prior commit → all outputs 0 immediately; a fresh frame after deassert loads correctly.
